pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline.
- Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB buffers: write-enables, flushes and global hold.
- Generates ALU operand forwarding selects from EX/MEM and MEM/WB.
- Small FSM covers load-use bubbles, branch flushes and multi-cycle data-memory waits, with a wait-timeout watchdog.

Parameters:
MEM_TIMEOUT, 16, MEM_WAIT cycles before the timeout flag sets (range 1..255).

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
in_ID_rs  input  5  rs of the instruction in ID
in_ID_rt  input  5  rt of the instruction in ID
in_ID_uses_rt  input  1  ID instruction reads rt
in_EX_rs  input  5  rs of the instruction in EX
in_EX_rt  input  5  rt of the instruction in EX (operand and load destination)
in_EX_MemRead  input  1  instruction in EX is a load
in_MEM_Reg_Write_addr  input  5  EX/MEM destination register
in_MEM_RegWrite  input  1  EX/MEM RegWrite
in_WB_Reg_Write_addr  input  5  MEM/WB destination register
in_WB_RegWrite  input  1  MEM/WB RegWrite
in_Branch_taken  input  1  branch resolved taken in EX
in_MEM_access  input  1  MEM stage issues a data-memory load or store
in_DM_ready  input  1  data memory completes the access this cycle
out_PC_Write  output  1  PC update enable
out_IFID_Write  output  1  IF/ID load enable
out_IFID_Flush  output  1  IF/ID bubble insert
out_IDEX_Flush  output  1  ID/EX control zeroed
out_Pipe_Hold  output  1  freezes EX/MEM and MEM/WB
out_ForwardA  output  2  ALU A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
out_ForwardB  output  2  ALU B select: same encoding
out_State  output  2  FSM state, for debug
out_Mem_Timeout  output  1  sticky watchdog flag

Behaviour:
- FSM states:
  - RUN=00
  - LOAD_STALL=01
  - MEM_WAIT=10
  - state 11 unused; decodes as RUN on the next edge.
- Async reset values while RST=1:
  - State=RUN, wait counter=0, out_Mem_Timeout=0.
  - out_PC_Write=0, out_IFID_Write=0, out_IFID_Flush=1, out_IDEX_Flush=1, out_Pipe_Hold=0, out_ForwardA/B=00.
- Control outputs are combinational from state and inputs. State, counter and flag update on posedge CLK.
- Condition definitions:
  - memwait = in_MEM_access & ~in_DM_ready.
  - loaduse = in_EX_MemRead & (in_EX_rt!=0) & (in_EX_rt==in_ID_rs | (in_ID_uses_rt & in_EX_rt==in_ID_rt)).
- Priority, highest first:
  - memwait: PC_Write=0, IFID_Write=0, Pipe_Hold=1, no flushes; next state MEM_WAIT. In RUN this holds even when branch or loaduse are also true, which are then deferred.
  - Branch_taken: IFID_Flush=1, IDEX_Flush=1, PC_Write=1, IFID_Write=1. Overrides loaduse, since the dependent instruction is squashed. Next state RUN.
  - loaduse: PC_Write=0, IFID_Write=0, IDEX_Flush=1 for one cycle; next state LOAD_STALL.
  - Otherwise: PC_Write=1, IFID_Write=1, no flush, no hold.
- LOAD_STALL:
  - Lasts exactly one cycle; evaluates the same priority list, except loaduse is masked because EX now holds a bubble.
  - Next state RUN, or MEM_WAIT if memwait.
- MEM_WAIT:
  - Hold outputs stay asserted while memwait.
  - On the cycle in_DM_ready=1, the RUN decode applies combinationally in that same cycle, so a deferred branch or load-use is acted on then. Next state follows RUN rules.
- Wait counter (8 bit):
  - Clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - Saturates at MEM_TIMEOUT; on reaching it, sets out_Mem_Timeout. The flag is sticky until RST.
  - The FSM keeps holding after timeout; there is no forced release.
- Forwarding (each of A/B, using in_EX_rs / in_EX_rt):
  - 10 if in_MEM_RegWrite & addr!=0 & addr==operand.
  - Else 01 if the same test holds on the WB fields.
  - Else 00. EX/MEM takes priority over MEM/WB.
  - Forwarding is independent of state and still valid during hold.
- Reset asserted mid-MEM_WAIT: immediate return to RUN with the reset outputs above.

Optional Feature:
PERF_CNT_EN
- Defined:
  - Adds out_Stall_count[31:0], incremented each CLK where out_PC_Write=0 and RST=0.
  - Adds out_Flush_count[31:0], incremented each cycle where Branch_taken flush fires.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: both ports exist but are tied to 0, with no counter flops.

Test Plan:
- Load-use: EX load rt=5, ID rs=5 → one cycle PC_Write=0, IFID_Write=0, IDEX_Flush=1, State=01; next cycle State=00, PC_Write=1.
- Load into $0: EX load rt=0, ID rs=0 → no stall.
- Forwarding priority: MEM writes r3, WB writes r3, EX_rs=3 → ForwardA=10. MEM RegWrite=0 → ForwardA=01.
- Branch+load-use same cycle: Branch_taken=1 with loaduse true → IFID_Flush=IDEX_Flush=1, PC_Write=1, State stays 00.
- Memory wait: MEM_access=1, DM_ready low 3 cycles → Pipe_Hold=1 for 3 cycles, State=10. Ready cycle → Pipe_Hold=0, State returns 00. Timeout flag stays 0.
- Timeout and reset: MEM_TIMEOUT=4, DM_ready never rises → out_Mem_Timeout=1 after 4 MEM_WAIT cycles and hold persists. Assert RST mid-wait → State=00, flag=0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stage-buffer sequencing, ALU forwarding
// selects and a wait watchdog. Optional PERF_CNT_EN adds stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  in_ID_rs,
  input  logic [4:0]  in_ID_rt,
  input  logic        in_ID_uses_rt,
  input  logic [4:0]  in_EX_rs,
  input  logic [4:0]  in_EX_rt,
  input  logic        in_EX_MemRead,
  input  logic [4:0]  in_MEM_Reg_Write_addr,
  input  logic        in_MEM_RegWrite,
  input  logic [4:0]  in_WB_Reg_Write_addr,
  input  logic        in_WB_RegWrite,
  input  logic        in_Branch_taken,
  input  logic        in_MEM_access,
  input  logic        in_DM_ready,
  output logic        out_PC_Write,
  output logic        out_IFID_Write,
  output logic        out_IFID_Flush,
  output logic        out_IDEX_Flush,
  output logic        out_Pipe_Hold,
  output logic [1:0]  out_ForwardA,
  output logic [1:0]  out_ForwardB,
  output logic [1:0]  out_State,
  output logic        out_Mem_Timeout,
  output logic [31:0] out_Stall_count,
  output logic [31:0] out_Flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10,
    UNUSED     = 2'b11
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       memwait;
  logic       loaduse;
  logic       loaduse_eff;
  logic       branch_flush;

  // Data-memory handshake: an access raised with in_MEM_access is outstanding until
  // in_DM_ready is seen high in the same cycle; until then the whole pipe is held.
  assign memwait = in_MEM_access & ~in_DM_ready;
  assign loaduse = in_EX_MemRead & (in_EX_rt != 5'd0) &
                   ((in_EX_rt == in_ID_rs) | (in_ID_uses_rt & (in_EX_rt == in_ID_rt)));
  // After one bubble EX no longer holds the load, so the dependency is resolved.
  assign loaduse_eff = loaduse & (state != LOAD_STALL);
  assign branch_flush = ~RST & ~memwait & in_Branch_taken;

  function automatic logic [1:0] fwd_sel(input logic [4:0] operand,
                                         input logic       mem_we,
                                         input logic [4:0] mem_addr,
                                         input logic       wb_we,
                                         input logic [4:0] wb_addr);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && mem_addr != 5'd0 && mem_addr == operand)
      sel = 2'b10;
    else if (wb_we && wb_addr != 5'd0 && wb_addr == operand)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    out_PC_Write   = 1'b1;
    out_IFID_Write = 1'b1;
    out_IFID_Flush = 1'b0;
    out_IDEX_Flush = 1'b0;
    out_Pipe_Hold  = 1'b0;
    state_nxt      = RUN;
    out_ForwardA   = fwd_sel(in_EX_rs, in_MEM_RegWrite, in_MEM_Reg_Write_addr,
                             in_WB_RegWrite, in_WB_Reg_Write_addr);
    out_ForwardB   = fwd_sel(in_EX_rt, in_MEM_RegWrite, in_MEM_Reg_Write_addr,
                             in_WB_RegWrite, in_WB_Reg_Write_addr);
    if (RST) begin
      out_PC_Write   = 1'b0;
      out_IFID_Write = 1'b0;
      out_IFID_Flush = 1'b1;
      out_IDEX_Flush = 1'b1;
      out_ForwardA   = 2'b00;
      out_ForwardB   = 2'b00;
    end else if (memwait) begin
      out_PC_Write   = 1'b0;
      out_IFID_Write = 1'b0;
      out_Pipe_Hold  = 1'b1;
      state_nxt      = MEM_WAIT;
    end else if (in_Branch_taken) begin
      out_IFID_Flush = 1'b1;
      out_IDEX_Flush = 1'b1;
    end else if (loaduse_eff) begin
      out_PC_Write   = 1'b0;
      out_IFID_Write = 1'b0;
      out_IDEX_Flush = 1'b1;
      state_nxt      = LOAD_STALL;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= RUN;
      wait_cnt        <= 8'd0;
      out_Mem_Timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == MEM_WAIT) begin
        if (wait_cnt < TIMEOUT) begin
          wait_cnt <= wait_cnt + 8'd1;
          if ((wait_cnt + 8'd1) == TIMEOUT)
            out_Mem_Timeout <= 1'b1;
        end
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  assign out_State = state;

`ifdef PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_Stall_count <= 32'd0;
      out_Flush_count <= 32'd0;
    end else begin
      if (!out_PC_Write)
        out_Stall_count <= out_Stall_count + 32'd1;
      if (branch_flush)
        out_Flush_count <= out_Flush_count + 32'd1;
    end
  end
`else
  assign out_Stall_count = 32'd0;
  assign out_Flush_count = 32'd0;
`endif

endmodule
